// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI message arbiter: FSM state encoding,
// default word/length widths and a constant-foldable clog2.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    READ = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_LW = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_arb_skid.sv
// Two-entry skid buffer carrying a word plus its SOP/EOP/channel tags.
// The head entry is a register, so outputs stay stable while out_ready is low.
module spi_arb_skid
  import spi_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [CW-1:0] in_ch,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [CW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    count
);

  localparam int EW = DW + CW + 2;

  logic [EW-1:0] e0_reg;
  logic [EW-1:0] e1_reg;
  logic [EW-1:0] in_word;
  logic [1:0]    cnt_reg;
  logic          push;
  logic          pop;

  assign in_word  = {in_data, in_sop, in_eop, in_ch};
  assign pop      = out_ready && (cnt_reg != 2'd0);
  assign in_ready = (cnt_reg != 2'd2) || pop;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_reg  <= '0;
      e1_reg  <= '0;
      cnt_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_reg == 2'd0) e0_reg <= in_word;
          else                 e1_reg <= in_word;
          cnt_reg <= cnt_reg + 2'd1;
        end
        2'b01: begin
          e0_reg  <= e1_reg;
          cnt_reg <= cnt_reg - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (cnt_reg == 2'd1) begin
            e0_reg <= in_word;
          end else begin
            e0_reg <= e1_reg;
            e1_reg <= in_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign {out_data, out_sop, out_eop, out_ch} = e0_reg;
  assign out_valid = (cnt_reg != 2'd0);
  assign count     = cnt_reg;

endmodule

// File: rtl/spi_msg_arbiter.sv
// Round-robin sequencer draining N_CH SPI message FIFOs into one framed word stream.
// Define SPI_ARB_HEADER_EN to prefix each message with a {channel, len} header word.
module spi_msg_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DW      = DEF_DW,
  parameter  int LW      = DEF_LW,
  parameter  int GAP_CYC = 4,
  localparam int CH_W    = clog2(N_CH)
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  input  logic [N_CH-1:0]    CH_READY,
  input  logic [N_CH*LW-1:0] CH_LEN,
  input  logic [N_CH*DW-1:0] CH_Q,
  output logic [N_CH-1:0]    CH_RD_REQ,
  output logic [DW-1:0]      OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OUT_SOP,
  output logic               OUT_EOP,
  output logic [CH_W-1:0]    OUT_CH,
  output logic               BUSY
);

  localparam int GW = clog2(GAP_CYC + 1);

  arb_state_t      state_reg, state_next;
  logic [CH_W-1:0] ch_reg, ch_next;
  logic [CH_W-1:0] rr_reg, rr_next;
  logic [LW:0]     rem_reg, rem_next;
  logic [LW:0]     len_full_reg, len_full_next;
  logic            infl_reg, infl_sop_reg, infl_eop_reg;

  logic [DW-1:0]   q_arr   [N_CH];
  logic [LW-1:0]   len_arr [N_CH];
  logic [N_CH-1:0] mask_vec;
  logic [N_CH-1:0] eligible;
  logic            grant_ok;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W-1:0] scan_ch;
  logic [LW-1:0]   grant_len;
  logic [LW:0]     grant_full;

  logic [1:0]      occ;
  logic            pop;
  logic            credit_ok;
  logic            rd_fire;
  logic            first_rd;
  logic            eop_done;
  logic            hdr_push;
  logic [DW-1:0]   hdr_word;
  logic            skid_in_ready;
  logic            skid_in_valid;
  logic [DW-1:0]   skid_in_data;
  logic            skid_in_sop;
  logic            skid_in_eop;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [GW-1:0] cnt_reg;

      assign q_arr[gi]     = CH_Q[gi*DW +: DW];
      assign len_arr[gi]   = CH_LEN[gi*LW +: LW];
      assign mask_vec[gi]  = (cnt_reg != '0);
      assign CH_RD_REQ[gi] = rd_fire && (ch_reg == CH_W'(gi));

      // reloaded on the EOP transfer, so the GAP cycle itself counts as masked
      always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST)                                  cnt_reg <= '0;
        else if (eop_done && ch_reg == CH_W'(gi))  cnt_reg <= GW'(GAP_CYC);
        else if (cnt_reg != '0)                    cnt_reg <= cnt_reg - GW'(1);
      end
    end
  endgenerate

  assign eligible = CH_READY & ~mask_vec;

  always_comb begin
    grant_ok = 1'b0;
    grant_ch = '0;
    scan_ch  = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_ch = CH_W'((int'(rr_reg) + i) % N_CH);
      if (!grant_ok && eligible[scan_ch]) begin
        grant_ok = 1'b1;
        grant_ch = scan_ch;
      end
    end
  end

  assign grant_len  = len_arr[grant_ch];
  assign grant_full = (grant_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, grant_len};

  // Pop in the same cycle frees a slot, which is what allows one word per cycle.
  assign pop       = OUT_VALID && OUT_READY;
  assign credit_ok = ({1'b0, occ} + {2'b00, infl_reg}) < (3'd2 + {2'b00, pop});
  assign rd_fire   = (state_reg == READ) && (rem_reg != '0) && credit_ok;
  assign eop_done  = (state_reg == READ) && pop && OUT_EOP;
  assign hdr_push  = (state_reg == HDR);

`ifdef SPI_ARB_HEADER_EN
  logic [LW-1:0] len_raw_reg;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST)                               len_raw_reg <= '0;
    else if (state_reg == IDLE && grant_ok) len_raw_reg <= grant_len;
  end

  assign hdr_word = DW'({8'(ch_reg), 8'(len_raw_reg)});
  assign first_rd = 1'b0;
`else
  assign hdr_word = '0;
  assign first_rd = (rem_reg == len_full_reg);
`endif

  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    rr_next       = rr_reg;
    rem_next      = rem_reg;
    len_full_next = len_full_reg;
    if (rd_fire) rem_next = rem_reg - (LW+1)'(1);
    case (state_reg)
      IDLE: begin
        if (grant_ok) begin
          ch_next       = grant_ch;
          rem_next      = grant_full;
          len_full_next = grant_full;
`ifdef SPI_ARB_HEADER_EN
          state_next    = HDR;
`else
          state_next    = READ;
`endif
        end
      end
      HDR:  if (skid_in_ready) state_next = READ;
      READ: if (eop_done) state_next = GAP;
      GAP: begin
        rr_next    = (ch_reg == CH_W'(N_CH-1)) ? '0 : ch_reg + CH_W'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      ch_reg       <= '0;
      rr_reg       <= '0;
      rem_reg      <= '0;
      len_full_reg <= '0;
      infl_reg     <= 1'b0;
      infl_sop_reg <= 1'b0;
      infl_eop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      rr_reg       <= rr_next;
      rem_reg      <= rem_next;
      len_full_reg <= len_full_next;
      infl_reg     <= rd_fire;
      infl_sop_reg <= rd_fire && first_rd;
      infl_eop_reg <= rd_fire && (rem_reg == (LW+1)'(1));
    end
  end

  assign skid_in_valid = infl_reg || hdr_push;
  assign skid_in_data  = hdr_push ? hdr_word : q_arr[ch_reg];
  assign skid_in_sop   = hdr_push ? 1'b1 : infl_sop_reg;
  assign skid_in_eop   = hdr_push ? 1'b0 : infl_eop_reg;

  spi_arb_skid #(
    .DW (DW),
    .CW (CH_W)
  ) u_skid (
    .clk       (SYS_CLK),
    .rst_n     (RST),
    .in_data   (skid_in_data),
    .in_sop    (skid_in_sop),
    .in_eop    (skid_in_eop),
    .in_ch     (ch_reg),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (OUT_DATA),
    .out_sop   (OUT_SOP),
    .out_eop   (OUT_EOP),
    .out_ch    (OUT_CH),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .count     (occ)
  );

  assign BUSY = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_msg_arbiter.sv
// Directed bench for spi_msg_arbiter: a table of single-message vectors plus
// hand-written sequences for gap masking, round-robin order and mid-message reset.
module tb_spi_msg_arbiter;

  localparam int N_CH = 4;
  localparam int DW   = 16;
  localparam int LW   = 8;
  localparam int GAP  = 4;
`ifdef SPI_ARB_HEADER_EN
  localparam int HDR_EN = 1;
`else
  localparam int HDR_EN = 0;
`endif

  logic               SYS_CLK = 1'b0;
  logic               RST = 1'b0;
  logic [N_CH-1:0]    CH_READY = '0;
  logic [N_CH*LW-1:0] CH_LEN = '0;
  logic [N_CH*DW-1:0] CH_Q;
  logic [N_CH-1:0]    CH_RD_REQ;
  logic [DW-1:0]      OUT_DATA;
  logic               OUT_VALID;
  logic               OUT_READY = 1'b0;
  logic               OUT_SOP;
  logic               OUT_EOP;
  logic [1:0]         OUT_CH;
  logic               BUSY;

  int n_vec = 0;
  int n_bad = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  spi_msg_arbiter #(
    .N_CH    (N_CH),
    .DW      (DW),
    .LW      (LW),
    .GAP_CYC (GAP)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .CH_READY  (CH_READY),
    .CH_LEN    (CH_LEN),
    .CH_Q      (CH_Q),
    .CH_RD_REQ (CH_RD_REQ),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_SOP   (OUT_SOP),
    .OUT_EOP   (OUT_EOP),
    .OUT_CH    (OUT_CH),
    .BUSY      (BUSY)
  );

  // Channel FIFO model: word = {channel, running read count}, valid 1 cycle after RD_REQ.
  int            rd_cnt [N_CH];
  logic [DW-1:0] q_mem  [N_CH];

  initial for (int i = 0; i < N_CH; i++) begin
    rd_cnt[i] = 0;
    q_mem[i]  = '0;
  end

  always @(posedge SYS_CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (CH_RD_REQ[i]) begin
        q_mem[i]  <= {4'(i), 12'(rd_cnt[i])};
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_q
      assign CH_Q[gi*DW +: DW] = q_mem[gi];
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_pat(input int pat, input int cyc);
    case (pat)
      1:       return (cyc % 2) == 0;
      2:       return (cyc % 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Collect one message from channel ch; returns on the cycle its EOP word transfers.
  task automatic run_msg(input int ch, input int nw, input int pat, input int len_raw);
    int   start [N_CH];
    int   k, cyc, others;
    bit   hdr_pend, held_v;
    logic [20:0] held, now;
    for (int i = 0; i < N_CH; i++) start[i] = rd_cnt[i];
    k = 0; cyc = 0; held_v = 0; held = '0;
    hdr_pend = (HDR_EN != 0);
    while (k < nw && cyc < 4000) begin
      @(negedge SYS_CLK);
      OUT_READY = rdy_pat(pat, cyc);
      #1;
      if (CH_RD_REQ[ch]) CH_READY[ch] = 1'b0;
      now = {OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, OUT_DATA};
      if (held_v) chk("stall_hold", int'(now), int'(held));
      if (OUT_VALID && OUT_READY) begin
        if (hdr_pend) begin
          chk("hdr_word", int'(OUT_DATA), (ch << 8) | (len_raw & 8'hff));
          chk("hdr_sop_eop", int'({OUT_SOP, OUT_EOP}), 2);
          chk("hdr_ch", int'(OUT_CH), ch);
          hdr_pend = 0;
        end else begin
          chk("data", int'(OUT_DATA), (ch << 12) | ((start[ch] + k) & 12'hfff));
          chk("sop_eop", int'({OUT_SOP, OUT_EOP}),
              ((k == 0 && HDR_EN == 0) ? 2 : 0) + ((k == nw - 1) ? 1 : 0));
          chk("out_ch", int'(OUT_CH), ch);
          k++;
        end
      end
      held_v = OUT_VALID && !OUT_READY;
      held   = now;
      cyc++;
    end
    chk("msg_words", k, nw);
    chk("rd_pulses", rd_cnt[ch] - start[ch], nw);
    others = 0;
    for (int i = 0; i < N_CH; i++) if (i != ch) others += rd_cnt[i] - start[i];
    chk("rd_other_ch", others, 0);
    $display("msg ch=%0d words=%0d pattern=%0d cycles=%0d", ch, k, pat, cyc);
  endtask

  task automatic raise(input int ch, input int len);
    CH_LEN[ch*LW +: LW] = 8'(len);
    CH_READY[ch] = 1'b1;
  endtask

  typedef struct {
    int ch;
    int len;
    int pat;
    int exp_words;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, xfers;
    bit seen_idle;

    vecs[0] = '{ch: 1, len: 3, pat: 0, exp_words: 3};
    vecs[1] = '{ch: 2, len: 5, pat: 1, exp_words: 5};
    vecs[2] = '{ch: 3, len: 0, pat: 0, exp_words: 256};
    vecs[3] = '{ch: 0, len: 1, pat: 0, exp_words: 1};
    vecs[4] = '{ch: 2, len: 2, pat: 2, exp_words: 2};

    // reset state
    repeat (3) @(posedge SYS_CLK);
    #1;
    chk("rst_rd_req", int'(CH_RD_REQ), 0);
    chk("rst_outs", int'({OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, BUSY}), 0);
    chk("rst_data", int'(OUT_DATA), 0);
    @(negedge SYS_CLK);
    RST = 1'b1;
    OUT_READY = 1'b1;

    foreach (vecs[v]) begin
      raise(vecs[v].ch, vecs[v].len);
      run_msg(vecs[v].ch, vecs[v].exp_words, vecs[v].pat, vecs[v].len);
    end

    // ch1 re-requests right after EOP: masked for the gap, granted GAP_CYC+2 cycles later
    OUT_READY = 1'b1;
    raise(1, 1);
    run_msg(1, 1, 0, 1);
    raise(1, 1);
    n = 0; seen_idle = 0;
    while (n < 40 && !(seen_idle && BUSY)) begin
      @(negedge SYS_CLK);
      #1;
      n++;
      if (!BUSY) seen_idle = 1;
      chk("gap_no_rd", int'(CH_RD_REQ & {4{!seen_idle || !BUSY}}), 0);
    end
    chk("gap_regrant_delay", n, GAP + 2);
    CH_READY[1] = 1'b0;
    run_msg(1, 1, 0, 1);

    // asynchronous reset in the middle of a 4-word message
    raise(1, 4);
    xfers = 0; n = 0;
    while (xfers < 2 && n < 100) begin
      @(negedge SYS_CLK);
      #1;
      if (OUT_VALID && OUT_READY) xfers++;
      n++;
    end
    chk("mid_msg_reached", xfers, 2);
    @(negedge SYS_CLK);
    RST = 1'b0;
    #1;
    chk("mid_rst_rd_req", int'(CH_RD_REQ), 0);
    chk("mid_rst_outs", int'({OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, BUSY}), 0);
    chk("mid_rst_data", int'(OUT_DATA), 0);
    CH_READY = '0;
    repeat (2) @(negedge SYS_CLK);
    RST = 1'b1;
    @(negedge SYS_CLK);
    #1;
    chk("post_rst_idle", int'({OUT_VALID, BUSY}), 0);

    // rr=0 after reset: ch0 then ch2; ch0 re-raised inside its gap waits behind ch2
    raise(0, 2);
    raise(2, 2);
    run_msg(0, 2, 0, 2);
    raise(0, 2);
    run_msg(2, 2, 0, 2);
    run_msg(0, 2, 0, 2);

    repeat (5) @(negedge SYS_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
